bus_arbiter: RTL and testbench

Two-master arbiter and address decoder for the shared system bus between the drisc core (master 0) and a secondary master such as a DMA or video-refresh engine (master 1). It grants bus ownership round-robin with a bounded hold time and inserts a one-cycle turnaround between owners. It owns the latched bus address register and produces the RAM, user-input and video-controller strobes from it. It sits between the masters and the existing `ram`, `user_input` and `video_controller` instances, replacing the ad-hoc top-level address register and decode.

---
 rtl/bus_pkg.sv | 11 +
 rtl/bus_decoder.sv | 27 ++
 rtl/bus_arbiter.sv | 91 +++++++++
 tb/tb_bus_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared bus FSM states, default address map and region decode.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} bus_state_t;
  typedef enum logic [1:0] {RAM, INPUT, VIDEO} region_t;
  localparam logic [31:0] DEF_RAM_LIMIT = 32'h00fffffc;
  localparam logic [31:0] DEF_IO_LIMIT = 32'h01000000;
  function automatic region_t decode_region(input logic [31:0] a, input logic [31:0] ram_limit,
                                            input logic [31:0] io_limit);
    return a < ram_limit ? RAM : a < io_limit ? INPUT : VIDEO;
  endfunction
endpackage

// File: rtl/bus_decoder.sv
// bus_decoder: address-to-region decode, slave strobes and access error qualification.
module bus_decoder import bus_pkg::*; #(
  parameter logic [31:0] RAM_LIMIT = DEF_RAM_LIMIT,
  parameter logic [31:0] IO_LIMIT = DEF_IO_LIMIT
) (
  input  logic [31:0] address,
  input  logic        addr_valid,
  input  logic        wr,
  input  logic        rd,
  output logic        write_ram,
  output logic        read_ram,
  output logic        read_user_input,
  output logic        write_video_controller,
  output logic        err
);
  region_t region;
  logic rd_q;
  assign region = decode_region(address, RAM_LIMIT, IO_LIMIT);
  // a simultaneous write suppresses the read
  assign rd_q = rd & ~wr;
  assign write_ram = addr_valid & wr & (region == RAM);
  assign read_ram = addr_valid & rd_q & (region == RAM);
  assign read_user_input = addr_valid & rd_q & (region == INPUT);
  assign write_video_controller = addr_valid & wr & (region == VIDEO);
  assign err = (wr | rd) & (~addr_valid | (wr & rd) | (wr & (region == INPUT)) |
                            (rd_q & (region == VIDEO)));
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with bounded hold, turnaround and address latch.
module bus_arbiter import bus_pkg::*; #(
  parameter logic [31:0] RAM_LIMIT = DEF_RAM_LIMIT,
  parameter logic [31:0] IO_LIMIT = DEF_IO_LIMIT,
  parameter int MAX_HOLD = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  input  logic [1:0]  addr_we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [1:0]  wr,
  input  logic [1:0]  rd,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [31:0] address_reg,
  output logic [1:0]  data_size,
  output logic [31:0] wdata,
  output logic        wdata_en,
  output logic        write_ram,
  output logic        read_ram,
  output logic        read_user_input,
  output logic        write_video_controller,
  output logic        bus_err
);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);
  bus_state_t state;
  logic last, addr_valid, own0, own1, cur, win, own_wr, own_rd, err;
  logic [HW-1:0] hold_cnt;
  assign own0 = state == OWN0;
  assign own1 = state == OWN1;
  assign cur = own1;
  assign gnt = {own1, own0};
  // on a tie the master that did not win last time goes first
  assign win = req[1] & (~req[0] | ~last);
  assign own_wr = (own0 & wr[0]) | (own1 & wr[1]);
  assign own_rd = (own0 & rd[0]) | (own1 & rd[1]);
  assign data_size = own0 ? size0 : own1 ? size1 : 2'b00;
  assign wdata = own0 ? wdata0 : own1 ? wdata1 : 32'h0;
  assign wdata_en = own_wr & addr_valid;
  bus_decoder #(.RAM_LIMIT(RAM_LIMIT), .IO_LIMIT(IO_LIMIT)) u_dec (
    .address(address_reg),
    .addr_valid(addr_valid),
    .wr(own_wr),
    .rd(own_rd),
    .write_ram(write_ram),
    .read_ram(read_ram),
    .read_user_input(read_user_input),
    .write_video_controller(write_video_controller),
    .err(err)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      last <= 1'b1;
      hold_cnt <= '0;
      address_reg <= '0;
      addr_valid <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= err;
      if (own0 && addr_we[0]) begin
        address_reg <= addr0;
        addr_valid <= 1'b1;
      end else if (own1 && addr_we[1]) begin
        address_reg <= addr1;
        addr_valid <= 1'b1;
      end
      case (state)
        IDLE: if (|req) begin
          state <= win ? OWN1 : OWN0;
          last <= win;
          hold_cnt <= '0;
        end
        OWN0, OWN1: begin
          if (!req[cur] || (req[~cur] && hold_cnt == HOLD_TOP)) state <= TURN;
          else if (req[~cur]) hold_cnt <= hold_cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
          addr_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors with hand-computed expectations for bus_arbiter.
module tb_bus_arbiter;
  import bus_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic [1:0] req = '0, addr_we = '0, wr = '0, rd = '0, size0 = '0, size1 = '0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, data_size;
  logic [31:0] address_reg, wdata;
  logic wdata_en, write_ram, read_ram, read_user_input, write_video_controller, bus_err;
  logic [3:0] stb;
  int n_vec = 0, n_bad = 0;
  assign stb = {write_ram, read_ram, read_user_input, write_video_controller};
  bus_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .gnt(gnt), .addr_we(addr_we),
    .addr0(addr0), .addr1(addr1), .wr(wr), .rd(rd), .size0(size0), .size1(size1),
    .wdata0(wdata0), .wdata1(wdata1), .address_reg(address_reg), .data_size(data_size),
    .wdata(wdata), .wdata_en(wdata_en), .write_ram(write_ram), .read_ram(read_ram),
    .read_user_input(read_user_input), .write_video_controller(write_video_controller),
    .bus_err(bus_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask
  task automatic access(input string tag, input logic [31:0] a, input logic w, input logic r,
                        input logic [3:0] exp_s, input logic exp_e);
    addr_we = 2'b01;
    addr0 = a;
    cyc();
    addr_we = '0;
    wr = {1'b0, w};
    rd = {1'b0, r};
    #1;
    $display("access %h region %s", a, decode_region(a, DEF_RAM_LIMIT, DEF_IO_LIMIT).name());
    chk({tag, "_addr"}, address_reg, a);
    chk({tag, "_stb"}, {28'h0, stb}, {28'h0, exp_s});
    chk({tag, "_wen"}, {31'h0, wdata_en}, {31'h0, w});
    cyc();
    chk({tag, "_err"}, {31'h0, bus_err}, {31'h0, exp_e});
    wr = '0;
    rd = '0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_gnt", {30'h0, gnt}, 32'h0);
    chk("rst_addr", address_reg, 32'h0);
    chk("rst_err", {31'h0, bus_err}, 32'h0);
    chk("rst_stb", {28'h0, stb}, 32'h0);
    chk("rst_size", {30'h0, data_size}, 32'h0);
    // single master
    req = 2'b01;
    size0 = 2'd2;
    cyc();
    chk("single_gnt", {30'h0, gnt}, 32'h1);
    chk("single_size", {30'h0, data_size}, 32'h2);
    addr_we = 2'b01;
    addr0 = 32'h100;
    cyc();
    addr_we = '0;
    rd = 2'b01;
    #1;
    chk("single_addr", address_reg, 32'h100);
    chk("single_rdram", {31'h0, read_ram}, 32'h1);
    cyc();
    chk("single_err", {31'h0, bus_err}, 32'h0);
    rd = '0;
    req = '0;
    cyc();
    chk("single_rel", {30'h0, gnt}, 32'h0);
    cyc();
    // tie after reset
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    req = 2'b11;
    cyc();
    chk("tie_gnt0", {30'h0, gnt}, 32'h1);
    req = 2'b10;
    cyc();
    chk("tie_turn", {30'h0, gnt}, 32'h0);
    cyc();
    chk("tie_idle", {30'h0, gnt}, 32'h0);
    cyc();
    chk("tie_gnt1", {30'h0, gnt}, 32'h2);
    req = '0;
    cyc();
    cyc();
    // preemption: last is now 1, so master 0 wins the tie
    req = 2'b11;
    cyc();
    chk("pre_gnt0", {30'h0, gnt}, 32'h1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (gnt != 2'b01) break;
      n++;
    end
    chk("pre_hold", n, 16);
    chk("pre_turn", {30'h0, gnt}, 32'h0);
    cyc();
    chk("pre_idle", {30'h0, gnt}, 32'h0);
    cyc();
    chk("pre_gnt1", {30'h0, gnt}, 32'h2);
    rd = 2'b10;
    #1;
    chk("pre_nostb", {28'h0, stb}, 32'h0);
    cyc();
    chk("pre_err", {31'h0, bus_err}, 32'h1);
    rd = '0;
    cyc();
    chk("pre_errclr", {31'h0, bus_err}, 32'h0);
    req = 2'b01;
    cyc();
    cyc();
    cyc();
    chk("dec_gnt0", {30'h0, gnt}, 32'h1);
    // decode boundaries
    access("ram_top", 32'h00fffffb, 1'b0, 1'b1, 4'b0100, 1'b0);
    access("in_low", 32'h00fffffc, 1'b0, 1'b1, 4'b0010, 1'b0);
    access("in_high", 32'h00ffffff, 1'b0, 1'b1, 4'b0010, 1'b0);
    access("vid_wr", 32'h01000000, 1'b1, 1'b0, 4'b0001, 1'b0);
    access("vid_rd", 32'h01000000, 1'b0, 1'b1, 4'b0000, 1'b1);
    access("wrrd", 32'h00000010, 1'b1, 1'b1, 4'b1000, 1'b1);
    access("in_wr", 32'h00fffffc, 1'b1, 1'b0, 4'b0000, 1'b1);
    // non-owner isolation
    cyc();
    addr_we = 2'b10;
    addr1 = 32'h55;
    wr = 2'b10;
    #1;
    chk("iso_stb", {28'h0, stb}, 32'h0);
    chk("iso_wen", {31'h0, wdata_en}, 32'h0);
    cyc();
    chk("iso_addr", address_reg, 32'h00fffffc);
    chk("iso_err", {31'h0, bus_err}, 32'h0);
    addr_we = '0;
    wr = '0;
    // reset mid-transfer
    req = '0;
    cyc();
    req = 2'b10;
    cyc();
    cyc();
    chk("mid_gnt1", {30'h0, gnt}, 32'h2);
    addr_we = 2'b10;
    addr1 = 32'h200;
    cyc();
    addr_we = '0;
    wr = 2'b10;
    wdata1 = 32'hdeadbeef;
    size1 = 2'd3;
    #1;
    chk("mid_wram", {31'h0, write_ram}, 32'h1);
    chk("mid_wdata", wdata, 32'hdeadbeef);
    chk("mid_size", {30'h0, data_size}, 32'h3);
    chk("mid_wen", {31'h0, wdata_en}, 32'h1);
    reset = 1'b1;
    cyc();
    chk("mrst_gnt", {30'h0, gnt}, 32'h0);
    chk("mrst_stb", {28'h0, stb}, 32'h0);
    chk("mrst_addr", address_reg, 32'h0);
    chk("mrst_err", {31'h0, bus_err}, 32'h0);
    chk("mrst_wen", {31'h0, wdata_en}, 32'h0);
    chk("mrst_size", {30'h0, data_size}, 32'h0);
    wr = '0;
    reset = 1'b0;
    cyc();
    chk("mrst_idle", {30'h0, gnt}, 32'h2);
    chk("mrst_stb2", {28'h0, stb}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
